// File: rtl/mem_bus_arbiter.sv
// Arbiter sharing one single-outstanding memory bus between the fetch (I) and
// memory-stage (D) requesters, with a bounded D burst while fetch is waiting.
module mem_bus_arbiter #(
    parameter int unsigned D_BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ireq_valid,
    input  logic [63:0] ireq_addr,
    output logic        iresp_addr_ok,
    output logic        iresp_data_ok,
    output logic [31:0] iresp_data,
    input  logic        dreq_valid,
    input  logic [63:0] dreq_addr,
    input  logic [2:0]  dreq_size,
    input  logic [7:0]  dreq_strobe,
    input  logic [63:0] dreq_data,
    output logic        dresp_addr_ok,
    output logic        dresp_data_ok,
    output logic [63:0] dresp_data,
    output logic        mreq_valid,
    output logic [63:0] mreq_addr,
    output logic [2:0]  mreq_size,
    output logic [7:0]  mreq_strobe,
    output logic [63:0] mreq_data,
    input  logic        mresp_addr_ok,
    input  logic        mresp_data_ok,
    input  logic [63:0] mresp_data
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_BUSY_I = 2'b01,
        ST_BUSY_D = 2'b10
    } state_e;

    localparam int unsigned     CNT_W     = 4;
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(D_BURST_MAX);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] burst_q, burst_d;
    logic             mreq_valid_q, mreq_valid_d;
    logic [63:0]      mreq_addr_q, mreq_addr_d;
    logic [2:0]       mreq_size_q, mreq_size_d;
    logic [7:0]       mreq_strobe_q, mreq_strobe_d;
    logic [63:0]      mreq_data_q, mreq_data_d;
    logic             i_forced_s;

    // Fetch wins a tie only once D has used up its burst allowance.
    assign i_forced_s = ireq_valid && (burst_q == BURST_MAX);

    // Next-state, grant and request-latch logic.
    always_comb begin
        state_d       = state_q;
        burst_d       = burst_q;
        mreq_valid_d  = mreq_valid_q;
        mreq_addr_d   = mreq_addr_q;
        mreq_size_d   = mreq_size_q;
        mreq_strobe_d = mreq_strobe_q;
        mreq_data_d   = mreq_data_q;
        case (state_q)
            ST_IDLE: begin
                if (dreq_valid && !i_forced_s) begin
                    state_d       = ST_BUSY_D;
                    mreq_valid_d  = 1'b1;
                    mreq_addr_d   = dreq_addr;
                    mreq_size_d   = dreq_size;
                    mreq_strobe_d = dreq_strobe;
                    mreq_data_d   = dreq_data;
                    // burst_q < BURST_MAX here whenever fetch is waiting
                    if (ireq_valid) begin
                        burst_d = burst_q + 4'd1;
                    end else begin
                        burst_d = 4'd0;
                    end
                end else if (ireq_valid) begin
                    state_d       = ST_BUSY_I;
                    mreq_valid_d  = 1'b1;
                    mreq_addr_d   = ireq_addr;
                    mreq_size_d   = 3'b010;
                    mreq_strobe_d = 8'h00;
                    mreq_data_d   = 64'h0;
                    burst_d       = 4'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (mresp_data_ok) begin
                    state_d      = ST_IDLE;
                    mreq_valid_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                mreq_valid_d = 1'b0;
            end
        endcase
    end

    // State, burst counter and downstream request registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            burst_q       <= 4'd0;
            mreq_valid_q  <= 1'b0;
            mreq_addr_q   <= 64'h0;
            mreq_size_q   <= 3'b000;
            mreq_strobe_q <= 8'h00;
            mreq_data_q   <= 64'h0;
        end else begin
            state_q       <= state_d;
            burst_q       <= burst_d;
            mreq_valid_q  <= mreq_valid_d;
            mreq_addr_q   <= mreq_addr_d;
            mreq_size_q   <= mreq_size_d;
            mreq_strobe_q <= mreq_strobe_d;
            mreq_data_q   <= mreq_data_d;
        end
    end

    // Response routing: only the owner of the in-flight transaction sees handshakes.
    always_comb begin
        iresp_addr_ok = 1'b0;
        iresp_data_ok = 1'b0;
        iresp_data    = 32'h0;
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        case (state_q)
            ST_BUSY_I: begin
                iresp_addr_ok = mresp_addr_ok;
                iresp_data_ok = mresp_data_ok;
                iresp_data    = mreq_addr_q[2] ? mresp_data[63:32] : mresp_data[31:0];
            end
            ST_BUSY_D: begin
                dresp_addr_ok = mresp_addr_ok;
                dresp_data_ok = mresp_data_ok;
            end
            default: begin
                iresp_addr_ok = 1'b0;
                dresp_addr_ok = 1'b0;
            end
        endcase
    end

    assign dresp_data  = mresp_data;
    assign mreq_valid  = mreq_valid_q;
    assign mreq_addr   = mreq_addr_q;
    assign mreq_size   = mreq_size_q;
    assign mreq_strobe = mreq_strobe_q;
    assign mreq_data   = mreq_data_q;

endmodule
